sram_bus_arbiter: RTL

//  Shares one SRAM-like bus (req/addr_ok/data_ok) between CPU instruction fetch (F stage) and data access (M stage).

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/arb_grant_sel.sv | 33 +++
 rtl/sram_bus_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM bus arbiter: FSM state and grant encodings.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_t;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational grant pick between instruction fetch and data access.
// With ARB_ROUND_ROBIN_EN defined, a tie goes to the requester not granted last;
// otherwise data always wins over fetch.
module arb_grant_sel
    import sram_arb_pkg::*;
(
    input  logic inst_req,
    input  logic data_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic valid,
    output logic pick
);

    // Decide who would be granted if the arbiter were idle this cycle
    always_comb begin
        valid = inst_req | data_req;
        pick  = GNT_INST;
`ifdef ARB_ROUND_ROBIN_EN
        if (inst_req && data_req) begin
            pick = (last_grant == GNT_INST) ? GNT_DATA : GNT_INST;
        end else if (data_req) begin
            pick = GNT_DATA;
        end
`else
        if (data_req) begin
            pick = GNT_DATA;
        end
`endif
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between CPU instruction fetch and data access.
// One transaction is outstanding at a time; stalls are combinational.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie breaking).
module sram_bus_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_stall,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_sel,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_stall,
    input  logic                flush,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata
);

    state_t state;
    grant_t grant;
    logic   cancel;
    logic   pick_valid;
    logic   pick;
    logic   cancel_now;
    logic   resp_done;
`ifdef ARB_ROUND_ROBIN_EN
    grant_t last_grant;
`endif

    arb_grant_sel u_grant_sel (
        .inst_req   (inst_req),
        .data_req   (data_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant (last_grant),
`endif
        .valid      (pick_valid),
        .pick       (pick)
    );

    // A flush arriving in the response cycle itself still suppresses the fetch result
    assign cancel_now = cancel | (flush & (grant == GNT_INST));
    assign resp_done  = ((state == ADDR) & bus_addr_ok & bus_data_ok) |
                        ((state == DATA) & bus_data_ok);

    assign inst_stall = inst_req & ~((state == DONE) & (grant == GNT_INST));
    assign data_stall = data_req & ~((state == DONE) & (grant == GNT_DATA));

    // Transaction FSM with registered bus fields and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GNT_INST;
            cancel     <= 1'b0;
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_wstrb  <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= GNT_INST;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cancel <= 1'b0;
                    if (pick_valid) begin
                        grant   <= grant_t'(pick);
                        state   <= ADDR;
                        bus_req <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= grant_t'(pick);
`endif
                        if (pick == GNT_DATA) begin
                            bus_wr    <= data_wr;
                            bus_wstrb <= data_wr ? data_sel : '0;
                            bus_addr  <= data_addr;
                            bus_wdata <= data_wdata;
                        end else begin
                            bus_wr    <= 1'b0;
                            bus_wstrb <= '0;
                            bus_addr  <= inst_addr;
                            bus_wdata <= '0;
                        end
                    end
                end
                ADDR: begin
                    if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if ((state == ADDR || state == DATA) && flush && grant == GNT_INST) begin
                cancel <= 1'b1;
            end

            if (resp_done) begin
                if (grant == GNT_DATA) begin
                    if (!bus_wr) begin
                        data_rdata <= bus_rdata;
                    end
                end else if (!cancel_now) begin
                    inst_rdata <= bus_rdata;
                end
                if (cancel_now) begin
                    state  <= IDLE;
                    cancel <= 1'b0;
                end else begin
                    state <= DONE;
                end
            end
        end
    end

endmodule
